// File: rtl/lut_eval_pkg.sv
// Shared sizing helpers and the default truth table for the LUT evaluator.
// The default table is for the 3-input / 2-output configuration.
package lut_eval_pkg;

    // Default 3-in/2-out table. Entries 0..7 read 0,1,1,2,1,3,2,3.
    localparam logic [15:0] DEF_INIT_TABLE = 16'hED94;

    function automatic int tbl_depth(input int n_in);
        return 2 ** n_in;
    endfunction

    // Bit offset of entry idx inside a packed table of n_out-bit entries.
    function automatic int ent_lo(input int idx, input int n_out);
        return idx * n_out;
    endfunction

endpackage

// File: rtl/lut_table.sv
// Runtime-writable truth table: one synchronous write port and one combinational read port.
// Reset reloads every entry from INIT_TABLE.
module lut_table
    import lut_eval_pkg::*;
#(
    parameter int N_IN  = 3,
    parameter int N_OUT = 2,
    parameter logic [N_OUT*(2**N_IN)-1:0] INIT_TABLE = DEF_INIT_TABLE
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             we,
    input  logic [N_IN-1:0]  waddr,
    input  logic [N_OUT-1:0] wdata,
    input  logic [N_IN-1:0]  raddr,
    output logic [N_OUT-1:0] rdata
);

    localparam int DEPTH = tbl_depth(N_IN);

    logic [N_OUT-1:0] mem_reg [DEPTH];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_reg[i] <= INIT_TABLE[ent_lo(i, N_OUT) +: N_OUT];
            end
        end else if (we) begin
            mem_reg[waddr] <= wdata;
        end
    end

    // Read sees the pre-edge contents, so a same-edge write only affects later lookups.
    assign rdata = mem_reg[raddr];

endmodule

// File: rtl/lut_eval_pipe.sv
// Two-stage valid/ready truth-table evaluator with reloadable table and a
// saturating count of results handed off downstream.
module lut_eval_pipe
    import lut_eval_pkg::*;
#(
    parameter int N_IN  = 3,
    parameter int N_OUT = 2,
    parameter int CNT_W = 16,
    parameter logic [N_OUT*(2**N_IN)-1:0] INIT_TABLE = DEF_INIT_TABLE
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cfg_we,
    input  logic [N_IN-1:0]  cfg_addr,
    input  logic [N_OUT-1:0] cfg_data,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [N_IN-1:0]  in_x,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [N_OUT-1:0] out_z,
    output logic [CNT_W-1:0] res_cnt
);

    logic             s1_valid_reg;
    logic [N_IN-1:0]  s1_x_reg;
    logic             out_valid_reg;
    logic [N_OUT-1:0] out_z_reg;
    logic [CNT_W-1:0] res_cnt_reg;
    logic [N_OUT-1:0] lut_rdata;
    logic             s1_load;
    logic             s2_load;
    logic             hand_off;

    lut_table #(
        .N_IN       (N_IN),
        .N_OUT      (N_OUT),
        .INIT_TABLE (INIT_TABLE)
    ) u_table (
        .clk   (clk),
        .rst   (rst),
        .we    (cfg_we),
        .waddr (cfg_addr),
        .wdata (cfg_data),
        .raddr (s1_x_reg),
        .rdata (lut_rdata)
    );

    // Stage 2 can take a new item when empty or when its current item leaves this cycle.
    assign s2_load  = s1_valid_reg && (!out_valid_reg || out_ready);
    assign in_ready = !s1_valid_reg || s2_load;
    assign s1_load  = in_valid && in_ready;
    assign hand_off = out_valid_reg && out_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid_reg <= 1'b0;
            s1_x_reg     <= '0;
        end else if (s1_load) begin
            s1_valid_reg <= 1'b1;
            s1_x_reg     <= in_x;
        end else if (s2_load) begin
            s1_valid_reg <= 1'b0;
        end
    end

    // On drain out_z keeps its last value; only the valid flag drops.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid_reg <= 1'b0;
            out_z_reg     <= '0;
        end else if (s2_load) begin
            out_valid_reg <= 1'b1;
            out_z_reg     <= lut_rdata;
        end else if (hand_off) begin
            out_valid_reg <= 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            res_cnt_reg <= '0;
        end else if (hand_off && (res_cnt_reg != {CNT_W{1'b1}})) begin
            res_cnt_reg <= res_cnt_reg + CNT_W'(1);
        end
    end

    assign out_valid = out_valid_reg;
    assign out_z     = out_z_reg;
    assign res_cnt   = res_cnt_reg;

endmodule

// File: tb/tb_lut_eval_pipe.sv
// Directed, table-driven bench for lut_eval_pipe; a second instance with a
// 3-bit counter runs on the same stimulus to exercise counter saturation.
module tb_lut_eval_pipe;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       cfg_we = 1'b0;
    logic [2:0] cfg_addr = '0;
    logic [1:0] cfg_data = '0;
    logic       in_valid = 1'b0;
    logic [2:0] in_x = '0;
    logic       out_ready = 1'b1;
    logic       in_ready, out_valid;
    logic [1:0] out_z;
    logic [15:0] res_cnt;
    logic       in_ready_s, out_valid_s;
    logic [1:0] out_z_s;
    logic [2:0] res_cnt_s;

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int acc_cnt = 0;
    int first_acc_cyc = -1;
    int first_val_cyc = -1;
    logic [1:0] outq [$];

    typedef struct {
        logic [2:0] x;
        logic [1:0] z;
    } vec_t;
    vec_t vecs [8];

    lut_eval_pipe dut (
        .clk(clk), .rst(rst), .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_data(cfg_data),
        .in_valid(in_valid), .in_ready(in_ready), .in_x(in_x),
        .out_valid(out_valid), .out_ready(out_ready), .out_z(out_z), .res_cnt(res_cnt)
    );

    lut_eval_pipe #(.CNT_W(3)) dut_sat (
        .clk(clk), .rst(rst), .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_data(cfg_data),
        .in_valid(in_valid), .in_ready(in_ready_s), .in_x(in_x),
        .out_valid(out_valid_s), .out_ready(out_ready), .out_z(out_z_s), .res_cnt(res_cnt_s)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Handshakes are sampled mid-cycle; each one completes on the following rising edge.
    always @(negedge clk) begin
        if (!rst) begin
            if (out_valid && out_ready) outq.push_back(out_z);
            if (in_valid && in_ready) begin
                acc_cnt++;
                if (first_acc_cyc < 0) first_acc_cyc = cyc;
            end
            if (out_valid && first_val_cyc < 0) first_val_cyc = cyc;
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end else begin
            $display("ok   %s: %0d", name, act);
        end
    endtask

    task automatic push(input logic [2:0] x);
        bit got = 1'b0;
        in_valid = 1'b1;
        in_x = x;
        for (int t = 0; t < 50; t++) begin
            @(negedge clk);
            if (in_ready) begin
                got = 1'b1;
                break;
            end
        end
        if (!got) begin
            errors++;
            checks++;
            $display("FAIL push_timeout: got in_ready=0 expected 1 for x=%0d", x);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic pop_chk(input string name, input int exp);
        if (outq.size() == 0) begin
            chk({name, "_present"}, 0, 1);
        end else begin
            chk(name, int'(outq.pop_front()), exp);
        end
    endtask

    initial begin
        int c0;
        logic [1:0] held_z;

        vecs[0] = '{3'd0, 2'd0}; vecs[1] = '{3'd1, 2'd1};
        vecs[2] = '{3'd2, 2'd1}; vecs[3] = '{3'd3, 2'd2};
        vecs[4] = '{3'd4, 2'd1}; vecs[5] = '{3'd5, 2'd3};
        vecs[6] = '{3'd6, 2'd2}; vecs[7] = '{3'd7, 2'd3};

        // Reset state
        idle(2);
        @(negedge clk);
        chk("rst_out_valid", int'(out_valid), 0);
        chk("rst_out_z", int'(out_z), 0);
        chk("rst_res_cnt", int'(res_cnt), 0);
        chk("rst_in_ready", int'(in_ready), 1);
        @(posedge clk); #1;
        rst = 1'b0;

        // Default table, streamed back-to-back
        out_ready = 1'b1;
        c0 = cyc;
        for (int i = 0; i < 8; i++) push(vecs[i].x);
        chk("stream_cycles", cyc - c0, 8);
        idle(4);
        for (int i = 0; i < 8; i++) pop_chk($sformatf("default_z[%0d]", i), int'(vecs[i].z));
        chk("latency", first_val_cyc - first_acc_cyc, 2);
        chk("default_res_cnt", int'(res_cnt), 8);
        chk("default_queue_empty", outq.size(), 0);

        // Backpressure: only two of three inputs accepted while stalled
        out_ready = 1'b0;
        c0 = acc_cnt;
        push(3'd5);
        push(3'd6);
        in_valid = 1'b1;
        in_x = 3'd7;
        @(negedge clk);
        held_z = out_z;
        chk("bp_held_z_first", int'(held_z), 3);
        for (int t = 0; t < 3; t++) begin
            @(negedge clk);
            chk($sformatf("bp_in_ready[%0d]", t), int'(in_ready), 0);
            chk($sformatf("bp_z_stable[%0d]", t), int'(out_z), int'(held_z));
        end
        chk("bp_accepted", acc_cnt - c0, 2);
        @(posedge clk); #1;
        out_ready = 1'b1;
        push(3'd7);
        idle(4);
        pop_chk("bp_z0", 3);
        pop_chk("bp_z1", 2);
        pop_chk("bp_z2", 3);
        chk("bp_no_dup", outq.size(), 0);
        chk("bp_res_cnt", int'(res_cnt), 11);

        // Reprogram entry 5
        cfg_we = 1'b1; cfg_addr = 3'd5; cfg_data = 2'd0;
        @(posedge clk); #1;
        cfg_we = 1'b0;
        push(3'd5);
        push(3'd4);
        idle(4);
        pop_chk("reprog_x5", 0);
        pop_chk("reprog_x4", 1);

        // Collision: write addr 3 on the edge where x=3 moves to stage 2
        push(3'd3);
        cfg_we = 1'b1; cfg_addr = 3'd3; cfg_data = 2'd1;
        @(posedge clk); #1;
        cfg_we = 1'b0;
        push(3'd3);
        idle(4);
        pop_chk("collide_old", 2);
        pop_chk("collide_new", 1);

        // Reset mid-stream with both stages full and entry 0 rewritten
        cfg_we = 1'b1; cfg_addr = 3'd0; cfg_data = 2'd3;
        @(posedge clk); #1;
        cfg_we = 1'b0;
        out_ready = 1'b0;
        push(3'd1);
        push(3'd2);
        @(negedge clk);
        chk("pre_rst_in_ready", int'(in_ready), 0);
        #2;
        rst = 1'b1;
        #1;
        chk("async_rst_out_valid", int'(out_valid), 0);
        chk("async_rst_res_cnt", int'(res_cnt), 0);
        chk("async_rst_in_ready", int'(in_ready), 1);
        @(posedge clk); #1;
        rst = 1'b0;
        outq.delete();
        out_ready = 1'b1;
        push(3'd0);
        idle(4);
        pop_chk("post_rst_x0", 0);
        chk("post_rst_queue_empty", outq.size(), 0);
        chk("post_rst_res_cnt", int'(res_cnt), 1);

        // Saturation of a 3-bit counter over ten fresh hand-offs
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        outq.delete();
        for (int i = 0; i < 6; i++) push(3'(i));
        idle(4);
        chk("sat_cnt_6", int'(res_cnt_s), 6);
        for (int i = 6; i < 10; i++) push(3'(i));
        idle(4);
        chk("sat_cnt_stop", int'(res_cnt_s), 7);
        chk("wide_cnt_10", int'(res_cnt), 10);
        chk("sat_queue_len", outq.size(), 10);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
